// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter sharing the single CLINT register port between NR_PORTS requesters.
// An owner may lock the port across accesses (64-bit timer halves); abandoned locks time out.
module clint_bus_arbiter #(
    parameter int NR_PORTS     = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NR_PORTS-1:0]                 req_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS-1:0]                 we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_PORTS-1:0]                 lock_i,
    output logic [NR_PORTS-1:0]                 gnt_o,
    output logic [NR_PORTS-1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                dev_req_o,
    output logic [ADDR_WIDTH-1:0]               dev_addr_o,
    output logic                                dev_we_o,
    output logic [DATA_WIDTH-1:0]               dev_wdata_o,
    input  logic                                dev_gnt_i,
    input  logic                                dev_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               dev_rdata_i,
    output logic                                lock_timeout_o
);
    localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NR_PORTS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, LOCKED} state_t;

    state_t                state_reg, state_next;
    logic [PTR_W-1:0]      owner_reg, rr_reg, winner, grant_idx;
    logic                  win_found, grant_valid, rsp_hit, timeout_hit, owner_req;
    logic                  lock_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    // Scan downward so the lowest offset from the pointer is the last (winning) hit.
    always_comb begin : rr_search
        int               idx;
        logic [PTR_W-1:0] idx_p;
        winner    = rr_reg;
        win_found = 1'b0;
        idx       = 0;
        idx_p     = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            idx = int'(rr_reg) + i;
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            idx_p = PTR_W'(idx);
            if (req_i[idx_p]) begin
                winner    = idx_p;
                win_found = 1'b1;
            end
        end
    end

    assign owner_req   = req_i[owner_reg];
    assign timeout_hit = (LOCK_TIMEOUT != 0) && !owner_req && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (grant_valid) state_next = ISSUE;
            ISSUE:    if (dev_gnt_i) state_next = WAIT_RSP;
            WAIT_RSP: if (dev_rvalid_i) state_next = lock_reg ? LOCKED : IDLE;
            LOCKED: begin
                if (owner_req)        state_next = ISSUE;
                else if (timeout_hit) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted, even if requests are present.
    always_comb begin
        grant_valid    = 1'b0;
        grant_idx      = winner;
        dev_req_o      = 1'b0;
        rsp_hit        = 1'b0;
        lock_timeout_o = 1'b0;
        if (rst_ni) begin
            unique case (state_reg)
                IDLE:     grant_valid = win_found;
                ISSUE:    dev_req_o = 1'b1;
                WAIT_RSP: rsp_hit = dev_rvalid_i;
                LOCKED: begin
                    grant_idx      = owner_reg;
                    grant_valid    = owner_req;
                    lock_timeout_o = timeout_hit;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
        assign gnt_o[gi]    = grant_valid && (grant_idx == PTR_W'(gi));
        assign rvalid_o[gi] = rsp_hit && (owner_reg == PTR_W'(gi));
    end

    assign rdata_o     = rsp_hit ? dev_rdata_i : '0;
    assign dev_addr_o  = addr_reg;
    assign dev_we_o    = we_reg;
    assign dev_wdata_o = wdata_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_reg <= '0;
            rr_reg    <= '0;
            lock_reg  <= 1'b0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
        end else begin
            if (grant_valid) begin
                owner_reg <= grant_idx;
                addr_reg  <= addr_i[grant_idx];
                we_reg    <= we_i[grant_idx];
                wdata_reg <= wdata_i[grant_idx];
                lock_reg  <= lock_i[grant_idx];
                // Locked re-grants leave the pointer alone so the lock does not skew fairness.
                if (state_reg == IDLE)
                    rr_reg <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
            end else if (state_reg == LOCKED && timeout_hit) begin
                lock_reg <= 1'b0;
            end
            if (state_reg == WAIT_RSP)
                cnt_reg <= '0;
            else if (state_reg == LOCKED && !owner_req && LOCK_TIMEOUT != 0)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed bench for clint_bus_arbiter: a per-cycle vector table for fairness and spurious
// inputs, followed by hand-written sequences for locking, timeout, backpressure and reset.
module tb_clint_bus_arbiter;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LT = 16;
    localparam int NV = 17;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NP-1:0]         req_i, we_i, lock_i, gnt_o, rvalid_o;
    logic [NP-1:0][AW-1:0] addr_i;
    logic [NP-1:0][DW-1:0] wdata_i;
    logic [DW-1:0]         rdata_o, dev_wdata_o, dev_rdata_i;
    logic [AW-1:0]         dev_addr_o;
    logic                  dev_req_o, dev_we_o, dev_gnt_i, dev_rvalid_i, lock_timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NP-1:0] req;
        logic          dgnt;
        logic          drv;
        logic [DW-1:0] rdata;
        logic [NP-1:0] e_gnt;
        logic [NP-1:0] e_rv;
        logic [DW-1:0] e_rdata;
        logic          e_dreq;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs[NV];

    always #5 clk_i = ~clk_i;

    clint_bus_arbiter #(
        .NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .lock_i(lock_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
        .dev_wdata_o(dev_wdata_o), .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
        .dev_rdata_i(dev_rdata_i), .lock_timeout_o(lock_timeout_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [AW-1:0] port_addr(input int k);
        return 16'h4000 + AW'(k * 8);
    endfunction

    function automatic vec_t mk_vec(input logic [NP-1:0] req, input logic dgnt, input logic drv,
                                    input logic [DW-1:0] rdata, input logic [NP-1:0] e_gnt,
                                    input logic [NP-1:0] e_rv, input logic [DW-1:0] e_rdata,
                                    input logic e_dreq, input logic [AW-1:0] e_addr);
        vec_t v;
        v.req = req; v.dgnt = dgnt; v.drv = drv; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_dreq = e_dreq; v.e_addr = e_addr;
        return v;
    endfunction

    // Holds reset for one edge, checks the reset-state outputs, then releases.
    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = '0;
        @(negedge clk_i);
        check("rst.ctl", 64'({gnt_o, rvalid_o, dev_req_o, dev_we_o, lock_timeout_o}), 64'(0));
        check("rst.data", rdata_o | dev_wdata_o | 64'(dev_addr_o), 64'(0));
        cyc();
        rst_ni = 1'b1;
    endtask

    // Grants port p with lock=1 and completes one access, leaving the DUT in its first LOCKED cycle.
    task automatic lock_port(input int p, input logic [NP-1:0] others);
        req_i = NP'(1 << p); lock_i = NP'(1 << p); addr_i[p] = 16'hBFF8;
        @(negedge clk_i); check("lk.gnt", 64'(gnt_o), 64'(NP'(1 << p))); cyc();
        req_i = others; lock_i = '0; dev_gnt_i = 1'b1;
        @(negedge clk_i); check("lk.dreq", 64'(dev_req_o), 64'(1)); cyc();
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1; dev_rdata_i = 64'h77;
        @(negedge clk_i); check("lk.rv", 64'(rvalid_o), 64'(NP'(1 << p))); cyc();
        dev_rvalid_i = 1'b0;
    endtask

    initial begin
        // Spurious dev_rvalid/dev_gnt in IDLE, then fairness 0,1,2,3,0 with all ports requesting.
        vecs[0] = mk_vec('0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, '0, '0, '0, 1'b0, '0);
        vecs[1] = mk_vec('0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0002, '0, '0, '0, 1'b0, '0);
        for (int j = 0; j < 5; j++) begin
            int k;
            logic [DW-1:0] d;
            k = j % NP;
            d = {32'hC0DE_0000, 32'(j)};
            vecs[2 + 3*j] = mk_vec(4'hF, 1'b1, 1'b0, '0, NP'(1 << k), '0, '0, 1'b0, '0);
            vecs[3 + 3*j] = mk_vec(4'hF, 1'b1, 1'b0, '0, '0, '0, '0, 1'b1, port_addr(k));
            vecs[4 + 3*j] = mk_vec(4'hF, 1'b1, 1'b1, d, '0, NP'(1 << k), d, 1'b0, '0);
        end

        do_reset();
        for (int k = 0; k < NP; k++) addr_i[k] = port_addr(k);
        for (int r = 0; r < NV; r++) begin
            req_i = vecs[r].req; dev_gnt_i = vecs[r].dgnt;
            dev_rvalid_i = vecs[r].drv; dev_rdata_i = vecs[r].rdata;
            @(negedge clk_i);
            check($sformatf("v%0d.gnt", r), 64'(gnt_o), 64'(vecs[r].e_gnt));
            check($sformatf("v%0d.rvalid", r), 64'(rvalid_o), 64'(vecs[r].e_rv));
            check($sformatf("v%0d.rdata", r), rdata_o, vecs[r].e_rdata);
            check($sformatf("v%0d.ctl", r), 64'({dev_req_o, lock_timeout_o}), 64'({vecs[r].e_dreq, 1'b0}));
            if (vecs[r].e_dreq)
                check($sformatf("v%0d.addr", r), 64'(dev_addr_o), 64'(vecs[r].e_addr));
            $display("vec %0d: req=%b gnt=%b rvalid=%b dev_req=%b", r, req_i, gnt_o, rvalid_o, dev_req_o);
            cyc();
        end

        // Lock pair: port 2 writes 0x4000 locked then 0x4004 unlocked; port 0 must wait.
        do_reset();
        addr_i[2] = 16'h4000; we_i[2] = 1'b1; wdata_i[2] = 64'hAAAA_0001; lock_i[2] = 1'b1; req_i = 4'b0100;
        @(negedge clk_i); check("lp.gnt1", 64'(gnt_o), 64'(4'b0100)); cyc();
        req_i = 4'b0001; lock_i = '0; dev_gnt_i = 1'b1;
        @(negedge clk_i);
        check("lp.addr1", 64'({dev_req_o, dev_we_o, dev_addr_o}), 64'({1'b1, 1'b1, 16'h4000}));
        check("lp.wdata1", dev_wdata_o, 64'hAAAA_0001);
        cyc();
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1; dev_rdata_i = 64'h11;
        @(negedge clk_i); check("lp.rv1", 64'({gnt_o, rvalid_o}), 64'({4'b0000, 4'b0100})); cyc();
        dev_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); check($sformatf("lp.stall%0d", i), 64'({gnt_o, dev_req_o}), 64'(0)); cyc();
        end
        req_i = 4'b0101; addr_i[2] = 16'h4004; wdata_i[2] = 64'hAAAA_0002;
        @(negedge clk_i); check("lp.gnt2", 64'(gnt_o), 64'(4'b0100)); cyc();
        req_i = 4'b0001; dev_gnt_i = 1'b1;
        @(negedge clk_i); check("lp.addr2", 64'({dev_req_o, dev_addr_o}), 64'({1'b1, 16'h4004})); cyc();
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        @(negedge clk_i); check("lp.rv2", 64'(rvalid_o), 64'(4'b0100)); cyc();
        dev_rvalid_i = 1'b0;
        @(negedge clk_i); check("lp.gnt0", 64'(gnt_o), 64'(4'b0001)); cyc();
        $display("lock pair done");

        // Timeout: port 1 goes silent after locking; port 3 is granted after the pulse.
        do_reset();
        lock_port(1, 4'b1000);
        for (int i = 0; i <= LT; i++) begin
            @(negedge clk_i);
            check($sformatf("to.c%0d", i), 64'({gnt_o, lock_timeout_o}), 64'({4'b0000, i == LT}));
            cyc();
        end
        @(negedge clk_i); check("to.gnt3", 64'(gnt_o), 64'(4'b1000)); cyc();
        $display("lock timeout done");

        // Owner returns in the cycle the count reaches the limit: grant wins, no pulse.
        do_reset();
        lock_port(1, 4'b1000);
        for (int i = 0; i < LT; i++) begin
            @(negedge clk_i); check($sformatf("gw.c%0d", i), 64'({gnt_o, lock_timeout_o}), 64'(0)); cyc();
        end
        req_i = 4'b1010;
        @(negedge clk_i); check("gw.gnt", 64'({gnt_o, lock_timeout_o}), 64'({4'b0010, 1'b0})); cyc();
        req_i = '0;
        @(negedge clk_i); check("gw.dreq", 64'(dev_req_o), 64'(1)); cyc();
        $display("grant-wins-over-timeout done");

        // Read with backpressure: port 3 reads 0xBFF8, dev_gnt after 5 cycles, response 3 later.
        do_reset();
        addr_i[3] = 16'hBFF8; req_i = 4'b1000;
        @(negedge clk_i); check("bp.gnt", 64'(gnt_o), 64'(4'b1000)); cyc();
        req_i = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            dev_gnt_i = (i == 4);
            @(negedge clk_i);
            check($sformatf("bp.iss%0d", i), 64'({gnt_o, dev_req_o, dev_we_o, dev_addr_o}),
                  64'({4'b0000, 1'b1, 1'b0, 16'hBFF8}));
            cyc();
        end
        dev_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dev_rvalid_i = (i == 2);
            dev_rdata_i  = (i == 2) ? 64'h1234_5678_9ABC_DEF0 : 64'hFFFF_0000_FFFF_0000;
            @(negedge clk_i);
            check($sformatf("bp.rv%0d", i), 64'({gnt_o, rvalid_o, dev_req_o}),
                  64'({4'b0000, (i == 2) ? 4'b1000 : 4'b0000, 1'b0}));
            check($sformatf("bp.rdata%0d", i), rdata_o, (i == 2) ? 64'h1234_5678_9ABC_DEF0 : 64'(0));
            cyc();
        end
        dev_rvalid_i = 1'b0;
        @(negedge clk_i); check("bp.next", 64'(gnt_o), 64'(4'b0001)); cyc();
        $display("read backpressure done");

        // Reset during WAIT_RSP: everything drops, pointer returns to 0.
        do_reset();
        req_i = 4'b0010; lock_i = 4'b0010;
        @(negedge clk_i); check("rm.gnt", 64'(gnt_o), 64'(4'b0010)); cyc();
        req_i = 4'b0101; dev_gnt_i = 1'b1;
        @(negedge clk_i); check("rm.dreq", 64'(dev_req_o), 64'(1)); cyc();
        dev_gnt_i = 1'b0; rst_ni = 1'b0; dev_rvalid_i = 1'b1; dev_rdata_i = 64'h5555;
        @(negedge clk_i);
        check("rm.ctl", 64'({gnt_o, rvalid_o, dev_req_o, dev_we_o, lock_timeout_o}), 64'(0));
        check("rm.data", rdata_o | dev_wdata_o | 64'(dev_addr_o), 64'(0));
        cyc();
        rst_ni = 1'b1; dev_rvalid_i = 1'b0;
        @(negedge clk_i); check("rm.gnt0", 64'(gnt_o), 64'(4'b0001)); cyc();
        $display("reset mid-op done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
